mux_arb: RTL and testbench
==========================

MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (>=2).
REQ-002 SHALL have parameter WIDTH, default 8, data width per channel.
REQ-003 SHALL have parameter RR, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority (channel 0 highest).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  N_CH  per-channel request.
REQ-007 SHALL have port in_data  input  N_CH x WIDTH  per-channel payload.
REQ-008 SHALL have port in_ready  output  N_CH  per-channel accept; at most one bit high.
REQ-009 SHALL have port out_valid  output  1  output register holds valid word.
REQ-010 SHALL have port out_data  output  WIDTH  registered payload.
REQ-011 SHALL have port out_ch  output  clog2(N_CH)  channel index of out_data.
REQ-012 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-013 SHALL transfer channel i when in_valid[i] and in_ready[i] are both high at a rising edge; likewise output transfer on out_valid and out_ready.
REQ-014 SHALL implement two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL define "can_load" = EMPTY, or FULL with out_ready=1.
REQ-016 SHALL drive in_ready[g]=1 only for the granted channel g, and only when can_load; all other in_ready bits 0.
REQ-017 SHALL grant, in RR=1, the first requesting channel scanning from ptr upward with wrap N_CH-1 -> 0.
REQ-018 SHALL grant, in RR=0, the lowest-index requesting channel; ptr is ignored.
REQ-019 SHALL update ptr to g+1 (mod N_CH) only on an accepted input transfer; ptr unchanged otherwise.
REQ-020 SHALL register in_data[g] and g into out_data/out_ch one cycle after acceptance (latency 1).
REQ-021 SHALL transition EMPTY -> FULL on accept; FULL -> EMPTY on output transfer with no accept; FULL -> FULL on simultaneous drain and accept (throughput 1 word/cycle).
REQ-022 SHALL hold out_valid, out_data, out_ch stable while FULL and out_ready=0 (backpressure), with all in_ready 0.
REQ-023 SHALL generate grant combinationally from in_valid and ptr only; in_ready SHALL NOT depend on in_data.
REQ-024 SHALL produce no grant and keep state when no in_valid bit is high.

Reset
REQ-025 SHALL, when reset=0 at a rising edge, set state EMPTY, out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-026 SHALL hold all in_ready at 0 while reset=0.
REQ-027 SHALL discard any word held in the output register on reset mid-operation.

Structure
REQ-028 SHALL place the state enum (EMPTY, FULL) and channel-index width helper in shared package mux_pkg.
REQ-029 SHALL implement arbitration in sub-module mux_rr_arbiter (inputs req, ptr, RR; output one-hot grant and index).
REQ-030 SHALL reject N_CH<2 or WIDTH<1 at elaboration.

Verification (N_CH=4, WIDTH=8)
REQ-031 SHALL cover: reset=0 for 2 cycles with all in_valid=1 -> out_valid=0, in_ready=0000, out_ch=0.
REQ-032 SHALL cover: RR=1, in_valid=1111, data 0x10/0x11/0x12/0x13, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_data 0x10..0x13.
REQ-033 SHALL cover: RR=1, ptr=3, in_valid=1001 -> grant ch3, then ch0 (wrap-around).
REQ-034 SHALL cover: RR=0, in_valid=0110 held 3 cycles, out_ready=1 -> out_ch 1,1,1; ch2 starved.
REQ-035 SHALL cover: FULL with 0xA5, out_ready=0 for 3 cycles -> out_data=0xA5 stable, in_ready=0000; out_ready=1 -> next word loaded same edge.
REQ-036 SHALL cover: reset=0 while FULL -> out_valid=0 next edge, ptr=0, held word not emitted.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the multiplexing arbiter: output-register state
// encoding and the channel-index width used on out_ch and the round-robin pointer.
package mux_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Width of a channel index; never narrower than one bit.
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Combinational arbiter: picks one requesting channel, either round-robin from
// ptr upward (RR=1) or lowest index first (RR=0), as a one-hot grant plus index.
module mux_rr_arbiter
   import mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int RR   = 1,
   localparam int IW  = ch_w(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [N_CH-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int c;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int k = 0; k < N_CH; k++) begin
         // Visit channels in priority order; the first requester wins.
         c = (RR != 0) ? ((int'(ptr) + k) % N_CH) : k;
         if (!any && req[c]) begin
            any      = 1'b1;
            grant[c] = 1'b1;
            idx      = IW'(c);
         end
      end
   end

endmodule

// File: rtl/mux_arb.sv
// N-channel to one multiplexer with a single-entry output register; one word
// per cycle throughput, in_ready offered only to the granted channel.
module mux_arb
   import mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   parameter int RR    = 1,
   localparam int IW   = ch_w(N_CH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_CH-1:0]            in_valid,
   input  logic [N_CH-1:0][WIDTH-1:0] in_data,
   output logic [N_CH-1:0]            in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic [IW-1:0]              out_ch,
   input  logic                       out_ready
);

   if (N_CH < 2 || WIDTH < 1) begin : g_bad_param
      $error("mux_arb: N_CH must be >= 2 and WIDTH >= 1");
   end

   state_t                state_q;
   state_t                state_d;
   logic [IW-1:0]         ptr_q;
   logic [N_CH-1:0]       grant;
   logic [IW-1:0]         gidx;
   logic                  gany;
   logic                  can_load;
   logic                  load;
   logic signed [WIDTH-1:0] data_p1;
   logic [IW-1:0]         ch_p1;

   mux_rr_arbiter #(
      .N_CH (N_CH),
      .RR   (RR)
   ) u_arb (
      .req   (in_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   // Grant depends only on requests and pointer; reset masks every ready.
   assign can_load = (state_q == EMPTY) || out_ready;
   assign load     = reset && can_load && gany;
   assign in_ready = load ? grant : '0;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = FULL;
      end else if (state_q == FULL && out_ready) begin
         state_d = EMPTY;
      end
   end

   // Stage p1: output register, loaded on accepted input transfer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_p1 <= '0;
         ch_p1   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            data_p1 <= in_data[gidx];
            ch_p1   <= gidx;
            ptr_q   <= (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
         end
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_p1;
   assign out_ch    = ch_p1;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: directed table of vectors, fixed-priority starvation
// sequence, and randomized traffic against a per-cycle reference model.
module tb_mux_arb;

   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     in_valid;
   logic [N-1:0][W-1:0] in_data;
   logic             out_ready;

   logic [N-1:0]     rr_in_ready, fp_in_ready;
   logic             rr_out_valid, fp_out_valid;
   logic [W-1:0]     rr_out_data, fp_out_data;
   logic [1:0]       rr_out_ch, fp_out_ch;

   int vectors = 0;
   int miscompares = 0;

   // reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT
   bit   m_full [2];
   int   m_data [2];
   int   m_ch   [2];
   int   m_ptr  [2];

   always #5 clk = ~clk;

   mux_arb #(.N_CH(N), .WIDTH(W), .RR(1)) u_rr (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
      .out_ch(rr_out_ch), .out_ready(out_ready));

   mux_arb #(.N_CH(N), .WIDTH(W), .RR(0)) u_fp (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
      .out_ch(fp_out_ch), .out_ready(out_ready));

   typedef struct {
      bit          rst_n;
      bit [3:0]    vld;
      bit [31:0]   data;
      bit          ordy;
      bit [3:0]    exp_rdy;
      bit          exp_ov;
      bit [7:0]    exp_od;
      bit [1:0]    exp_ch;
      bit          chk_d;
   } vec_t;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner is the requester closest to ptr going upward (RR) or the lowest index.
   function automatic int model_grant(input bit [3:0] v, input int ptr, input bit rr);
      int best = -1;
      int bestd = N;
      for (int ch = 0; ch < N; ch++) begin
         int d;
         d = rr ? ((ch - ptr + N) % N) : ch;
         if (v[ch] && d < bestd) begin
            best  = ch;
            bestd = d;
         end
      end
      return best;
   endfunction

   function automatic bit [3:0] model_ready(input int m);
      int g;
      g = model_grant(in_valid, m_ptr[m], m == 0);
      if (reset && (!m_full[m] || out_ready) && g >= 0) return 4'(1 << g);
      return 4'b0000;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_full[m] = 0; m_data[m] = 0; m_ch[m] = 0; m_ptr[m] = 0;
      end
   endtask

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         int g;
         g = model_grant(in_valid, m_ptr[m], m == 0);
         if (!reset) begin
            m_full[m] = 0; m_data[m] = 0; m_ch[m] = 0; m_ptr[m] = 0;
         end else if ((!m_full[m] || out_ready) && g >= 0) begin
            m_full[m] = 1;
            m_data[m] = int'(in_data[g]);
            m_ch[m]   = g;
            m_ptr[m]  = (g + 1) % N;
         end else if (m_full[m] && out_ready) begin
            m_full[m] = 0;
         end
      end
   endtask

   task automatic check_model();
      cmp("rr_in_ready", 32'(rr_in_ready), 32'(model_ready(0)));
      cmp("fp_in_ready", 32'(fp_in_ready), 32'(model_ready(1)));
      cmp("rr_out_valid", 32'(rr_out_valid), 32'(m_full[0]));
      cmp("fp_out_valid", 32'(fp_out_valid), 32'(m_full[1]));
      if (m_full[0]) begin
         cmp("rr_out_data", 32'(rr_out_data), 32'(m_data[0]));
         cmp("rr_out_ch", 32'(rr_out_ch), 32'(m_ch[0]));
      end
      if (m_full[1]) begin
         cmp("fp_out_data", 32'(fp_out_data), 32'(m_data[1]));
         cmp("fp_out_ch", 32'(fp_out_ch), 32'(m_ch[1]));
      end
   endtask

   task automatic drive(input bit rst_n, input bit [3:0] vld, input bit [31:0] data, input bit ordy);
      reset     = rst_n;
      in_valid  = vld;
      in_data   = data;
      out_ready = ordy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   localparam bit [31:0] D = 32'h13121110;
   vec_t tbl [21];

   initial begin
      tbl = '{
         // reset held with all channels requesting
         '{0, 4'hF, D, 1, 4'b0000, 0, 8'h00, 2'd0, 1},
         // round-robin streaming 0,1,2,3,0
         '{1, 4'hF, D, 1, 4'b0001, 0, 8'h00, 2'd0, 1},
         '{1, 4'hF, D, 1, 4'b0010, 1, 8'h10, 2'd0, 1},
         '{1, 4'hF, D, 1, 4'b0100, 1, 8'h11, 2'd1, 1},
         '{1, 4'hF, D, 1, 4'b1000, 1, 8'h12, 2'd2, 1},
         '{1, 4'hF, D, 1, 4'b0001, 1, 8'h13, 2'd3, 1},
         '{1, 4'h0, D, 1, 4'b0000, 1, 8'h10, 2'd0, 1},
         // move ptr to 3, then wrap-around 3 -> 0
         '{1, 4'h4, D, 1, 4'b0100, 0, 8'h00, 2'd0, 0},
         '{1, 4'h9, D, 1, 4'b1000, 1, 8'h12, 2'd2, 1},
         '{1, 4'h9, D, 1, 4'b0001, 1, 8'h13, 2'd3, 1},
         '{1, 4'h0, D, 1, 4'b0000, 1, 8'h10, 2'd0, 1},
         // backpressure with 0xA5 held, then drain+load on the same edge
         '{1, 4'h1, 32'h000000A5, 0, 4'b0001, 0, 8'h00, 2'd0, 0},
         '{1, 4'h2, 32'h0000B600, 0, 4'b0000, 1, 8'hA5, 2'd0, 1},
         '{1, 4'h2, 32'h0000B600, 0, 4'b0000, 1, 8'hA5, 2'd0, 1},
         '{1, 4'h2, 32'h0000B600, 0, 4'b0000, 1, 8'hA5, 2'd0, 1},
         '{1, 4'h2, 32'h0000B600, 1, 4'b0010, 1, 8'hA5, 2'd0, 1},
         '{1, 4'h0, D, 0, 4'b0000, 1, 8'hB6, 2'd1, 1},
         // reset while FULL discards the held word and clears ptr
         '{0, 4'hF, D, 0, 4'b0000, 1, 8'hB6, 2'd1, 1},
         '{1, 4'h0, D, 1, 4'b0000, 0, 8'h00, 2'd0, 1},
         '{1, 4'hF, D, 1, 4'b0001, 0, 8'h00, 2'd0, 0},
         '{1, 4'h0, D, 1, 4'b0000, 1, 8'h10, 2'd0, 1}
      };

      model_reset();
      drive(0, 4'hF, D, 1);
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].vld, tbl[i].data, tbl[i].ordy);
         cmp($sformatf("tbl%0d_in_ready", i), 32'(rr_in_ready), 32'(tbl[i].exp_rdy));
         cmp($sformatf("tbl%0d_out_valid", i), 32'(rr_out_valid), 32'(tbl[i].exp_ov));
         if (tbl[i].chk_d) begin
            cmp($sformatf("tbl%0d_out_data", i), 32'(rr_out_data), 32'(tbl[i].exp_od));
            cmp($sformatf("tbl%0d_out_ch", i), 32'(rr_out_ch), 32'(tbl[i].exp_ch));
         end
         check_model();
         tick();
      end

      // fixed priority: channel 1 always beats channel 2
      drive(0, 4'h0, D, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, 4'b0110, D, 1);
         cmp("fp_starve_in_ready", 32'(fp_in_ready), 32'h2);
         check_model();
         tick();
         cmp("fp_starve_out_ch", 32'(fp_out_ch), 32'd1);
         cmp("fp_starve_out_data", 32'(fp_out_data), 32'h11);
         cmp("fp_starve_out_valid", 32'(fp_out_valid), 32'd1);
      end

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom % 64) != 0, 4'($urandom), $urandom, ($urandom % 4) != 0);
         check_model();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
